// File: rtl/ecdsa_arith_pkg.sv
// Shared definitions for the ECDSA field arithmetic datapath:
// engine FSM states, add/sub mode encoding and default operand geometry.
package ecdsa_arith_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PASS1,
        PASS2,
        SEL,
        DONE
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int DEF_WIDTH = 256;
    localparam int DEF_CHUNK = 16;

endpackage

// File: rtl/serial_mod_addsub_if.sv
// Operand/result handshake bundle between the operand register file,
// the serial add/sub engine and the point add/double sequencer.
interface serial_mod_addsub_if
    import ecdsa_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic             mod_en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] p;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag;

    modport master (
        output in_valid, mode, mod_en, a, b, p, out_ready,
        input  in_ready, out_valid, result, flag
    );

    modport slave (
        input  in_valid, mode, mod_en, a, b, p, out_ready,
        output in_ready, out_valid, result, flag
    );
endinterface

// File: rtl/addsub_slice.sv
// CHUNK-bit adder slice: {cout,s} = x + y + cin.
// Purely combinational, no latency, no flow control.
module addsub_slice #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);
    logic [CHUNK:0] sum;

    assign sum  = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    assign s    = sum[CHUNK-1:0];
    assign cout = sum[CHUNK];
endmodule

// File: rtl/serial_mod_addsub.sv
// Serial WIDTH-bit add/subtract, CHUNK bits per clock, optional reduction mod p.
// Latency: N cycles raw, 2N+1 cycles modular, from acceptance edge to out_valid.
// Backpressure: result/flag held until out_ready; in_ready stays low for the whole job.
module serial_mod_addsub
    import ecdsa_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_mod_addsub_if.slave    bus
);
    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    if (WIDTH % CHUNK != 0) begin : g_width_check
        $error("serial_mod_addsub: WIDTH must be a multiple of CHUNK");
    end

    state_t             state_q, state_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               c1_q, c1_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   p_q, p_d;
    logic               mode_q, mode_d;
    logic               mod_en_q, mod_en_d;
    logic [WIDTH-1:0]   t_q, t_d;
    logic [WIDTH-1:0]   u_q, u_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               flag_q, flag_d;
    logic               out_valid_q, out_valid_d;

    logic [CHUNK-1:0]   sl_x, sl_y, sl_s;
    logic               sl_cout;
    logic               corr;

    // PASS1 slices a/b, PASS2 re-reads the stored t against the modulus.
    always_comb begin
        sl_x = '0;
        sl_y = '0;
        if (state_q == PASS2) begin
            sl_x = t_q[int'(idx_q)*CHUNK +: CHUNK];
            sl_y = (mode_q == MODE_SUB) ? p_q[int'(idx_q)*CHUNK +: CHUNK]
                                        : ~p_q[int'(idx_q)*CHUNK +: CHUNK];
        end else begin
            sl_x = a_q[int'(idx_q)*CHUNK +: CHUNK];
            sl_y = (mode_q == MODE_SUB) ? ~b_q[int'(idx_q)*CHUNK +: CHUNK]
                                        : b_q[int'(idx_q)*CHUNK +: CHUNK];
        end
    end

    addsub_slice #(.CHUNK(CHUNK)) u_slice (
        .x    (sl_x),
        .y    (sl_y),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_cout)
    );

    // Add overflows past p if either pass carried; sub needs +p only on borrow.
    assign corr = (mode_q == MODE_SUB) ? ~c1_q : (c1_q | carry_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        c1_d        = c1_q;
        a_d         = a_q;
        b_d         = b_q;
        p_d         = p_q;
        mode_d      = mode_q;
        mod_en_d    = mod_en_q;
        t_d         = t_q;
        u_d         = u_q;
        result_d    = result_q;
        flag_d      = flag_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    p_d      = bus.p;
                    mode_d   = bus.mode;
                    mod_en_d = bus.mod_en;
                    carry_d  = bus.mode;
                    idx_d    = '0;
                    state_d  = PASS1;
                end
            end
            PASS1: begin
                t_d[int'(idx_q)*CHUNK +: CHUNK] = sl_s;
                carry_d = sl_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d = '0;
                    c1_d  = sl_cout;
                    if (mod_en_q) begin
                        state_d = PASS2;
                        carry_d = (mode_q == MODE_ADD);
                    end else begin
                        state_d     = DONE;
                        result_d    = t_d;
                        flag_d      = (mode_q == MODE_SUB) ? ~sl_cout : sl_cout;
                        out_valid_d = 1'b1;
                    end
                end
            end
            PASS2: begin
                u_d[int'(idx_q)*CHUNK +: CHUNK] = sl_s;
                carry_d = sl_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = SEL;
                end
            end
            SEL: begin
                result_d    = corr ? u_q : t_q;
                flag_d      = corr;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            c1_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            mode_q      <= MODE_ADD;
            mod_en_q    <= 1'b0;
            t_q         <= '0;
            u_q         <= '0;
            result_q    <= '0;
            flag_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            c1_q        <= c1_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p_q         <= p_d;
            mode_q      <= mode_d;
            mod_en_q    <= mod_en_d;
            t_q         <= t_d;
            u_q         <= u_d;
            result_q    <= result_d;
            flag_q      <= flag_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flag      = flag_q;
endmodule

// File: tb/tb_serial_mod_addsub.sv
// Bench for serial_mod_addsub at WIDTH=32/CHUNK=8, plus a default-size instance
// exercising the carry-out wrap case.
module tb_serial_mod_addsub;
    import ecdsa_arith_pkg::*;

    localparam int W = 32;
    localparam int C = 8;
    localparam int N = W / C;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_mod_addsub_if #(.WIDTH(W))   bus ();
    serial_mod_addsub_if #(.WIDTH(256)) bus2 ();

    serial_mod_addsub #(.WIDTH(W), .CHUNK(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    serial_mod_addsub dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         flag;
        int           lat;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    logic first_seen = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Field-level rules: plain sums/differences and comparisons against p.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] p, input logic mode,
                                         input logic mod_en);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         f;
        if (mode == MODE_ADD) begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0];
            f = s[W];
            if (mod_en) begin
                f = (s >= {1'b0, p});
                if (f) r = W'(s - {1'b0, p});
            end
        end else begin
            f = (a < b);
            r = a - b;
            if (mod_en && f) r = r + p;
        end
        return {f, r};
    endfunction

    // Compare process: every cycle with out_valid is checked against the head job.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", {255'd0, bus.out_valid}, 256'd0);
            end else begin
                if (!first_seen) begin
                    chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
                    first_seen = 1'b1;
                end
                chk("result", bus.result, exp_q[0].res);
                chk("flag", bus.flag, exp_q[0].flag);
                chk("in_ready_while_done", bus.in_ready, 1'b0);
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    first_seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] p,
                        input logic mode, input logic mod_en,
                        input logic [W-1:0] xres, input logic xflag, input string name);
        logic [W:0] m;
        exp_t       e;
        int         n;
        m = model(a, b, p, mode, mod_en);
        chk({name, "_model_result"}, m[W-1:0], xres);
        chk({name, "_model_flag"}, m[W], xflag);
        bus.a        = a;
        bus.b        = b;
        bus.p        = p;
        bus.mode     = mode;
        bus.mod_en   = mod_en;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) chk({name, "_in_ready_wait"}, bus.in_ready, 1'b1);
        @(posedge clk); #1;
        e.res  = m[W-1:0];
        e.flag = m[W];
        e.lat  = mod_en ? 2 * N + 1 : N;
        e.acc  = cyc;
        exp_q.push_back(e);
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.p        = $urandom;
        bus.mode     = 1'($urandom);
        bus.mod_en   = 1'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("job_timeout", exp_q.size(), 0);
            exp_q.delete();
            first_seen = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc2;
        int n;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.mode      = 1'b0;
        bus.mod_en    = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.p         = '0;
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b1;
        bus2.mode      = 1'b0;
        bus2.mod_en    = 1'b0;
        bus2.a         = '0;
        bus2.b         = '0;
        bus2.p         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", bus.in_ready, 1'b1);
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_result", bus.result, 32'd0);
        chk("reset_flag", bus.flag, 1'b0);
        chk("reset_in_ready_w256", bus2.in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;

        send(32'hFFFFFFFF, 32'h00000001, 32'h0, 1'b0, 1'b0, 32'h00000000, 1'b1, "raw_add_wrap");
        wait_done();
        send(32'h00000005, 32'h00000007, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b1, "raw_sub_borrow");
        wait_done();
        send(32'h00000007, 32'h00000005, 32'h0, 1'b1, 1'b0, 32'h00000002, 1'b0, "raw_sub_pos");
        wait_done();
        send(32'h12345678, 32'h11111111, 32'h0, 1'b0, 1'b0, 32'h23456789, 1'b0, "raw_add_plain");
        wait_done();
        send(32'hFFFFFFFA, 32'h00000002, 32'hFFFFFFFB, 1'b0, 1'b1, 32'h00000001, 1'b1, "mod_add_corr");
        wait_done();
        send(32'h00000001, 32'h00000002, 32'hFFFFFFFB, 1'b0, 1'b1, 32'h00000003, 1'b0, "mod_add_nocorr");
        wait_done();
        send(32'h80000000, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000001, 1'b1, "mod_add_carry");
        wait_done();
        send(32'd3, 32'd10, 32'd97, 1'b1, 1'b1, 32'd90, 1'b1, "mod_sub_corr");
        wait_done();
        send(32'd10, 32'd3, 32'd97, 1'b1, 1'b1, 32'd7, 1'b0, "mod_sub_nocorr");
        wait_done();

        // Default-size engine: all-ones plus one wraps to zero with carry out.
        bus2.a        = '1;
        bus2.b        = 256'd1;
        bus2.in_valid = 1'b1;
        @(posedge clk); #1;
        acc2 = cyc;
        bus2.in_valid = 1'b0;
        bus2.a        = '0;
        n = 0;
        while (!bus2.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("w256_latency", cyc - acc2, 16);
        chk("w256_result", bus2.result, 256'd0);
        chk("w256_flag", bus2.flag, 1'b1);
        @(posedge clk); #1;

        // Backpressure with a competing request while the result is held.
        bus.out_ready = 1'b0;
        send(32'h00000001, 32'h00000002, 32'hFFFFFFFB, 1'b0, 1'b1, 32'h00000003, 1'b0, "bp_job");
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        bus.a        = 32'h0000_00AA;
        bus.b        = 32'h0000_0055;
        bus.mode     = 1'b0;
        bus.mod_en   = 1'b0;
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid_held", bus.out_valid, 1'b1);
            chk("bp_in_ready_low", bus.in_ready, 1'b0);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_after", bus.in_ready, 1'b1);
        chk("bp_jobs_pending", exp_q.size(), 0);
        @(posedge clk); #1;
        send(32'd3, 32'd10, 32'd97, 1'b1, 1'b1, 32'd90, 1'b1, "bp_next");
        wait_done();

        // Reset on the second PASS1 cycle abandons the job.
        send(32'hFFFFFFFA, 32'h00000002, 32'hFFFFFFFB, 1'b0, 1'b1, 32'h00000001, 1'b1, "rst_victim");
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        first_seen = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_out_valid", bus.out_valid, 1'b0);
        chk("rst_mid_in_ready", bus.in_ready, 1'b1);
        chk("rst_mid_result", bus.result, 32'd0);
        chk("rst_mid_flag", bus.flag, 1'b0);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        send(32'hFFFFFFFA, 32'h00000002, 32'hFFFFFFFB, 1'b0, 1'b1, 32'h00000001, 1'b1, "rst_after");
        wait_done();
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
